bcd_serial_adder: RTL and testbench
===================================

// Module: bcd_serial_adder
// PURPOSE
//  Multi-digit BCD adder/subtractor, the parametrised successor of the one-digit BCD adder.
//  Adds or subtracts two DIGITS-wide packed-BCD operands, one digit per clock, LSD first.
//  Operands are captured under a start/busy/done handshake.
//  Result and carry/borrow are held in registers and drive char7seg displays continuously.
//  Sits between board switch/operand logic and the HEX display bank.
// PARAMETERS
//  DIGITS  4  number of BCD digits per operand (>=1); sets sum width and ADD state length
// PORTS
//  clk    in   1           system clock; all state changes on the rising edge
//  reset  in   1           synchronous, active-high reset
//  start  in   1           request; sampled only in IDLE
//  sub    in   1           0 = A+B+cin, 1 = A-B (ten's complement); captured with start
//  cin    in   1           decimal carry-in for add; ignored when sub=1
//  a      in   4*DIGITS    operand A, packed BCD, digit 0 in [3:0]
//  b      in   4*DIGITS    operand B, packed BCD
//  busy   out  1           high from the cycle after start is accepted through the ADD state
//  done   out  1           one-cycle pulse when sum/cout/err are updated
//  sum    out  4*DIGITS    registered result digits, held until next done
//  cout   out  1           add: final decimal carry; sub: 1 = borrow (A<B)
//  err    out  1           registered; 1 = an operand digit was >9 in the last operation
//  hex    out  7*(DIGITS+1) char7seg codes: hex[7i+:7] = sum digit i, top field = cout
// BEHAVIOUR
//  - Reset (sync): state=IDLE; busy=0, done=0, sum=0, cout=0, err=0; hex shows all zeros.
//  - FSM IDLE -> ADD -> DONE -> IDLE.
//    IDLE: start=1 captures a, b (nine's-complemented when sub=1) and sub;
//          carry0 = sub ? 1 : cin; digit index = 0; digit-valid check on raw a,b.
//    ADD: exactly DIGITS cycles, one digit each.
//         t = a_i + b'_i + c (5 bits, max 19); t>9 -> d=t-10, c=1; else d=t, c=0.
//         b'_i = sub ? 9-b_i : b_i. d is shifted into the result register MSD-ward.
//    DONE: one cycle; done=1; sum/cout/err commit; busy=0.
//  - Latency: start accepted at edge T -> done high during cycle T+DIGITS+1.
//    Next start is accepted in the cycle after DONE.
//  - cout: add = final c. Sub = ~final c; sum is the ten's-complement difference.
//  - Invalid digit (>9) in a or b: arithmetic still runs to completion.
//    At DONE, err=1, sum=0, cout=0.
//  - start during ADD/DONE is ignored (no queueing); a, b, sub, cin changes are ignored.
//  - sum/cout/err are unchanged between done pulses; hex tracks them combinationally.
//  - Reset mid-operation aborts: no done pulse; outputs return to reset values next edge.
//  - start and reset together: reset wins.
// TESTING (DIGITS=4)
//  1. Assert reset 2 cycles -> busy=0, done=0, sum=16'h0000, cout=0, err=0.
//  2. start, a=16'h1234, b=16'h5678, sub=0, cin=0 -> busy 4 cycles;
//     done 5 cycles after start; sum=16'h6912, cout=0.
//  3. Add 9999+0001, cin=0 -> sum=16'h0000, cout=1.
//     Add 9999+0000, cin=1 -> sum=16'h0000, cout=1.
//  4. Sub 0500-0123 -> sum=16'h0377, cout=0.
//     Sub 0123-0500 -> sum=16'h9623, cout=1.
//  5. a=16'h12A4, b=16'h0001 -> done pulse, err=1, sum=0, cout=0.
//     A following valid add clears err.
//  6. Pulse start again 2 cycles into ADD -> ignored; single done; correct result.
//     Then reset during ADD -> no done; sum=0; next start runs normally.

Source files
------------

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock, least significant digit first.
// The result registers drive a bank of char7seg display codes continuously.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      sub,
    input  logic                      cin,
    input  logic [4*DIGITS-1:0]       a,
    input  logic [4*DIGITS-1:0]       b,
    output logic                      busy,
    output logic                      done,
    output logic [4*DIGITS-1:0]       sum,
    output logic                      cout,
    output logic                      err,
    output logic [7*(DIGITS+1)-1:0]   hex
);

    // state  | meaning
    // IDLE   | waiting for start; operands captured on accept
    // ADD    | one digit per cycle, DIGITS cycles
    // DONE   | one cycle; done pulse, results committed
    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            c_q, c_d, sub_q, sub_d, bad_q, bad_d;
    logic            busy_q, busy_d, done_q, done_d, cout_q, cout_d, err_q, err_d;

    logic [4:0]      t;
    logic [3:0]      dig;
    logic            c_next;
    logic [W+3:0]    res_cat;
    logic [W-1:0]    res_shift;

    function automatic logic [W-1:0] nines(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'd9 - v[4*i +: 4];
        return r;
    endfunction

    function automatic logic has_bad(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++) r = r | (v[4*i +: 4] > 4'd9);
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        t = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, c_q};
        if (t > 5'd9) begin
            dig    = 4'(t - 5'd10);
            c_next = 1'b1;
        end else begin
            dig    = t[3:0];
            c_next = 1'b0;
        end
        res_cat   = {dig, res_q};
        res_shift = res_cat[W+3:4];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        sub_d   = sub_q;
        bad_d   = bad_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? nines(b) : b;
                    sub_d   = sub;
                    c_d     = sub | cin;
                    cnt_d   = CW'(DIGITS - 1);
                    bad_d   = has_bad(a) | has_bad(b);
                    busy_d  = 1'b1;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                a_d   = a_q >> 4;
                b_d   = b_q >> 4;
                c_d   = c_next;
                res_d = res_shift;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    // Invalid digits still run the full arithmetic; the result is just discarded.
                    if (bad_q) begin
                        sum_d  = '0;
                        cout_d = 1'b0;
                        err_d  = 1'b1;
                    end else begin
                        sum_d  = res_shift;
                        cout_d = sub_q ? ~c_next : c_next;
                        err_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            sub_q   <= 1'b0;
            bad_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            sub_q   <= sub_d;
            bad_q   <= bad_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        hex = '0;
        for (int i = 0; i < DIGITS; i++) hex[7*i +: 7] = seg7(sum_q[4*i +: 4]);
        hex[7*DIGITS +: 7] = seg7({3'b000, cout_q});
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Randomized bench for bcd_serial_adder: results are compared against an integer-arithmetic model.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MOD    = 10000;

    logic                    clk = 1'b0;
    logic                    reset, start, sub, cin;
    logic [W-1:0]            a, b;
    logic                    busy, done, cout, err;
    logic [W-1:0]            sum;
    logic [7*(DIGITS+1)-1:0] hex;

    int checks = 0;
    int errors = 0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout),
        .err(err), .hex(hex)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd_val(input logic [W-1:0] v);
        int r = 0;
        int p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r += int'(v[4*i +: 4]) * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic bit bcd_bad(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int n);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input int d);
        logic [6:0] tab [0:9];
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tab[d];
    endfunction

    function automatic logic [7*(DIGITS+1)-1:0] hex_of(input int val, input int c);
        logic [7*(DIGITS+1)-1:0] h = '0;
        for (int i = 0; i < DIGITS; i++) begin
            h[7*i +: 7] = seg7(val % 10);
            val = val / 10;
        end
        h[7*DIGITS +: 7] = seg7(c);
        return h;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // poke > 0: pulse start again that many cycles into ADD with unrelated operands.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input bit tsub, input bit tcin, input int poke);
        int  ev, ec, ee, n, busy_cnt, d;
        ee = 0; ec = 0; ev = 0;
        if (bcd_bad(ta) || bcd_bad(tb)) begin
            ee = 1;
        end else if (!tsub) begin
            d  = bcd_val(ta) + bcd_val(tb) + int'(tcin);
            ec = (d >= MOD) ? 1 : 0;
            ev = d % MOD;
        end else begin
            d  = bcd_val(ta) - bcd_val(tb);
            ec = (d < 0) ? 1 : 0;
            ev = (d < 0) ? d + MOD : d;
        end
        @(negedge clk);
        a = ta; b = tb; sub = tsub; cin = tcin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        busy_cnt = 0;
        while (!done && n < 20) begin
            if (busy) busy_cnt++;
            if (n == 1) begin
                a = $urandom; b = $urandom; sub = ~tsub; cin = ~tcin;
            end
            start = (poke > 0 && n == poke);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("done_seen", done, 1'b1);
        check("latency", n, DIGITS + 1);
        check("busy_cycles", busy_cnt, DIGITS);
        check("busy_at_done", busy, 1'b0);
        check("sum", sum, to_bcd(ev));
        check("cout", cout, ec);
        check("err", err, ee);
        check("hex", hex, hex_of(ev, ec));
        @(negedge clk);
        check("done_pulse", done, 1'b0);
        check("sum_held", sum, to_bcd(ev));
        if (poke > 0) begin
            repeat (DIGITS + 2) begin
                @(negedge clk);
                check("no_extra_done", done, 1'b0);
            end
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int dn;
        reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum", sum, 16'h0000);
        check("rst_cout", cout, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_hex", hex, hex_of(0, 0));

        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 0);
        check("dir_6912", sum, 16'h6912);
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 0);
        check("dir_9999p1", {cout, sum}, 17'h10000);
        run_op(16'h9999, 16'h0000, 1'b0, 1'b1, 0);
        check("dir_9999cin", {cout, sum}, 17'h10000);
        run_op(16'h0500, 16'h0123, 1'b1, 1'b0, 0);
        check("dir_sub_pos", {cout, sum}, 17'h00377);
        run_op(16'h0123, 16'h0500, 1'b1, 1'b1, 0);
        check("dir_sub_neg", {cout, sum}, 17'h19623);
        run_op(16'h12A4, 16'h0001, 1'b0, 1'b0, 0);
        check("dir_err", err, 1'b1);
        run_op(16'h0042, 16'h0017, 1'b0, 1'b0, 0);
        check("err_cleared", err, 1'b0);
        run_op(16'h4321, 16'h1111, 1'b0, 1'b1, 2);

        // Abort in the middle of ADD.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_sum", sum, 16'h0000);
        dn = 0;
        repeat (DIGITS + 3) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort_no_done", dn, 0);

        // start and reset in the same cycle: reset wins.
        start = 1'b1; reset = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        check("rst_beats_start", busy, 1'b0);

        for (int k = 0; k < 40; k++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 7) == 0) rb[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
